// File: rtl/bits_fetch.sv
`default_nettype none
//============================================================================
// Module  : bits_fetch
// Brief   : Fetches a bitstream from word memory into a show-ahead FIFO for
//           bitparse. Define BITS_FETCH_BYTESWAP_EN to byte-reverse each word.
// Revision: 1.0
//============================================================================
module bits_fetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] word_num,
    output logic          mem_rd_req,
    output logic [AW-1:0] mem_rd_addr,
    input  logic          mem_rd_rdy,
    input  logic          mem_rd_vld,
    input  logic [127:0]  mem_rd_data,
    output logic [127:0]  codec_data,
    output logic          codec_data_vld,
    input  logic          codec_data_rd_en,
    output logic          busy,
    output logic          done,
    output logic          underflow
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   word_num_q, word_num_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            outst_q, outst_d;
    logic            done_q, done_d;
    logic            uflow_q, uflow_d;
    logic [PW:0]     wr_ptr_q, rd_ptr_q;
    logic [127:0]    mem_q [DEPTH];

    logic [127:0]    w_push_data;
    logic [PW:0]     w_level;
    logic            w_empty, w_full, w_room;
    logic            w_req_acc, w_push, w_pop, w_start_acc;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign w_level = wr_ptr_q - rd_ptr_q;
    // Space must cover the words already buffered plus the one in flight.
    assign w_room  = ({1'b0, w_level} + {{(PW+1){1'b0}}, outst_q}) < DEPTH_W;

    assign mem_rd_req = (state_q == FETCH) && !outst_q && w_room;
    assign w_req_acc  = mem_rd_req && mem_rd_rdy;
    // Responses with nothing outstanding belong to a request from before reset.
    assign w_push     = mem_rd_vld && outst_q && !w_full;
    assign w_pop      = codec_data_rd_en && !w_empty;

`ifdef BITS_FETCH_BYTESWAP_EN
    for (genvar b = 0; b < 16; b++) begin : g_swap
        assign w_push_data[8*b +: 8] = mem_rd_data[8*(15-b) +: 8];
    end
`else
    assign w_push_data = mem_rd_data;
`endif

    always_comb begin
        state_d     = state_q;
        word_num_d  = word_num_q;
        addr_d      = addr_q;
        outst_d     = outst_q;
        done_d      = 1'b0;
        uflow_d     = uflow_q;
        w_start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    word_num_d  = word_num;
                    addr_d      = '0;
                    state_d     = (word_num == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (w_req_acc) begin
                    addr_d = addr_q + AW'(1);
                    if ((addr_q + AW'(1)) == word_num_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!outst_q && w_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_req_acc) begin
            outst_d = 1'b1;
        end else if (mem_rd_vld) begin
            outst_d = 1'b0;
        end
        if (w_start_acc) begin
            uflow_d = 1'b0;
        end
        if (codec_data_rd_en && w_empty) begin
            uflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            word_num_q <= '0;
            addr_q     <= '0;
            outst_q    <= 1'b0;
            done_q     <= 1'b0;
            uflow_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_num_q <= word_num_d;
            addr_q     <= addr_d;
            outst_q    <= outst_d;
            done_q     <= done_d;
            uflow_q    <= uflow_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= w_push_data;
        end
    end

    assign codec_data     = w_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
    assign codec_data_vld = !w_empty;
    assign mem_rd_addr    = addr_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign underflow      = uflow_q;

endmodule
`default_nettype wire
